// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: access-type codes, bus size encodings and FSM states shared by the load/store unit.
package lsu_mem_ctrl_pkg;
  localparam logic [2:0] LB_TYPE  = 3'd0;
  localparam logic [2:0] LBU_TYPE = 3'd1;
  localparam logic [2:0] LH_TYPE  = 3'd2;
  localparam logic [2:0] LHU_TYPE = 3'd3;
  localparam logic [2:0] LW_TYPE  = 3'd4;
  localparam logic [2:0] SB_TYPE  = 3'd5;
  localparam logic [2:0] SH_TYPE  = 3'd6;
  localparam logic [2:0] SW_TYPE  = 3'd7;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} lsu_state_e;
  function automatic logic [1:0] ls_size(input logic [2:0] t);
    return (t == LB_TYPE || t == LBU_TYPE || t == SB_TYPE) ? SIZE_B :
           (t == LH_TYPE || t == LHU_TYPE || t == SH_TYPE) ? SIZE_H : SIZE_W;
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_load_ext.sv
// lsu_load_ext: selects the addressed byte/halfword of a bus word and sign- or zero-extends it.
module lsu_load_ext
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  l_s_type,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr_lo, 3'b000} +: 8];
  assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign result = l_s_type == LB_TYPE  ? {{24{b[7]}}, b} :
                  l_s_type == LBU_TYPE ? {24'd0, b} :
                  l_s_type == LH_TYPE  ? {{16{h[15]}}, h} :
                  l_s_type == LHU_TYPE ? {16'd0, h} : rdata;
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller on an SRAM-like bus; ADDR_EXC_EN enables address-error exceptions.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [2:0]            l_s_type,
  input  logic                  memwrite,
  input  logic                  memtoreg,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  flush,
  output logic                  mem_stall,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_done,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic [ADDR_W-1:0]     badvaddr,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W/8-1:0]   data_wstrb,
  input  logic                  data_addr_ok,
  input  logic [DATA_W-1:0]     data_rdata,
  input  logic                  data_data_ok
);
  lsu_state_e state, state_nxt;
  logic addr_exc, start, cancel, cancel_eff, take;
  logic [1:0] size_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in, ext;
  logic [DATA_W/8-1:0] wstrb_in;
  logic [2:0] type_q;
  assign size_in = ls_size(l_s_type);
`ifdef ADDR_EXC_EN
  assign addr_exc = mem_valid & (memwrite | memtoreg) &
                    (size_in == SIZE_H ? mem_addr[0] : size_in == SIZE_W ? |mem_addr[1:0] : 1'b0);
  assign exc_adel = addr_exc & ~memwrite;
  assign exc_ades = addr_exc & memwrite;
  assign badvaddr = addr_exc ? mem_addr : '0;
  assign addr_in  = mem_addr;
`else
  assign addr_exc = 1'b0;
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
  assign badvaddr = '0;
  // Misaligned halfword/word addresses are silently rounded down.
  assign addr_in  = size_in == SIZE_H ? {mem_addr[ADDR_W-1:1], 1'b0} :
                    size_in == SIZE_W ? {mem_addr[ADDR_W-1:2], 2'b00} : mem_addr;
`endif
  assign start      = mem_valid & (memwrite | memtoreg) & ~flush & ~addr_exc;
  assign cancel_eff = cancel | flush;
  assign wdata_in   = size_in == SIZE_B ? {4{mem_wdata[7:0]}} :
                      size_in == SIZE_H ? {2{mem_wdata[15:0]}} : mem_wdata;
  assign wstrb_in   = !memwrite ? 4'b0000 :
                      size_in == SIZE_B ? 4'b0001 << addr_in[1:0] :
                      size_in == SIZE_H ? (addr_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign take = data_data_ok & ~cancel_eff & ~data_wr &
                ((state == S_REQ & data_addr_ok) | state == S_WAIT);
  lsu_load_ext u_ext (
    .rdata    (data_rdata),
    .addr_lo  (data_addr[1:0]),
    .l_s_type (type_q),
    .result   (ext)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_REQ : S_IDLE;
      S_REQ:   state_nxt = !data_addr_ok ? S_REQ : !data_data_ok ? S_WAIT : cancel_eff ? S_IDLE : S_DONE;
      S_WAIT:  state_nxt = !data_data_ok ? S_WAIT : cancel_eff ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    data_req  = state == S_REQ;
    mem_done  = state == S_DONE;
    mem_stall = state == S_IDLE ? start : state != S_DONE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cancel     <= 1'b0;
      data_addr  <= '0;
      data_size  <= SIZE_B;
      data_wr    <= 1'b0;
      data_wdata <= '0;
      data_wstrb <= '0;
      type_q     <= LB_TYPE;
      mem_rdata  <= '0;
    end else begin
      // A flushed access still has to drain its outstanding bus response.
      cancel <= (state == S_REQ || state == S_WAIT) && state_nxt != S_IDLE && cancel_eff;
      if (state == S_IDLE && start) begin
        data_addr  <= addr_in;
        data_size  <= size_in;
        data_wr    <= memwrite;
        data_wdata <= wdata_in;
        data_wstrb <= wstrb_in;
        type_q     <= l_s_type;
      end
      if (take) mem_rdata <= ext;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- MEM-stage load/store controller for the MIPS pipeline.
- Consumes the decoder's `l_s_type`, `memwrite` and `memtoreg` together with the ALU-computed address and store data.
- Issues one transaction per instruction on the SRAM-like data bus (req / addr_ok / data_ok), stalling the pipeline until it completes.
- Returns byte/halfword/word load data, already extended, to WB.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus and register data width (fixed at 32; `wstrb` is DATA_W/8).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  a valid instruction occupies MEM this cycle.
- l_s_type  in  3  access type (LB/LBU/LH/LHU/LW/SB/SH/SW type codes from the shared package).
- memwrite  in  1  instruction is a store.
- memtoreg  in  1  instruction is a load.
- mem_addr  in  32  effective address.
- mem_wdata  in  32  store data (rt), unaligned.
- flush  in  1  exception/flush: cancel the MEM instruction.
- mem_stall  out  1  freeze the pipeline up to and including MEM.
- mem_rdata  out  32  extended load result.
- mem_done  out  1  one-cycle pulse: access complete, `mem_rdata` valid.
- exc_adel / exc_ades  out  1 each  load / store address-error exception.
- badvaddr  out  32  faulting address.
- data_req  out  1  bus request.
- data_wr  out  1  write request.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  bus address.
- data_wdata  out  32  lane-replicated store data.
- data_wstrb  out  4  byte enables.
- data_addr_ok  in  1  request accepted.
- data_rdata  in  32  read data.
- data_data_ok  in  1  read data valid / write complete.

Behaviour:
- Reset (async, any state): FSM to IDLE; `data_req`, `mem_done` and `mem_stall` are 0; `mem_rdata`, bus address/data/strobe registers, `badvaddr` and the cancel flag are 0.
- start = mem_valid & (memwrite | memtoreg) & ~flush & ~addr_exc.
- IDLE:
  - `mem_stall` = start (combinational).
  - On start: register addr, size, wr, wdata, wstrb and l_s_type, then go to REQ.
- REQ:
  - `data_req` = 1; all bus fields held stable until `data_addr_ok`.
  - addr_ok=1 and data_ok=0 in the same cycle: go to WAIT.
  - addr_ok=1 and data_ok=1 in the same cycle: capture data and go to DONE.
  - `mem_stall` = 1.
- WAIT:
  - `data_req` = 0, `mem_stall` = 1.
  - On `data_data_ok`: register the extended data into `mem_rdata` and go to DONE.
- DONE:
  - `mem_done` = 1 and `mem_stall` = 0 for exactly one cycle, so the pipeline advances this cycle.
  - Unconditionally returns to IDLE; no back-to-back issue from DONE.
- Minimum load latency is 3 cycles from start to `mem_done`.
- Flush in IDLE: suppresses start.
- Flush in REQ or WAIT:
  - The issued request is not withdrawn; set `cancel` and keep `mem_stall` = 1 until data_ok.
  - Then return to IDLE without `mem_done` and without updating `mem_rdata`.
- Store formatting:
  - SB: wstrb = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111.
  - Loads drive wstrb = 0.
- Load extraction:
  - Byte lane selected by addr[1:0]; halfword selected by addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- `data_addr` is the full address; the slave ignores low bits using size.
- Unknown l_s_type with memtoreg or memwrite set is treated as a word access.

Optional Feature:
- Macro ADDR_EXC_EN.
- Defined:
  - addr_exc = (LH|LHU|SH) & addr[0], or (LW|SW) & (addr[1:0]!=0).
  - `exc_adel` (loads) or `exc_ades` (stores) asserts combinationally while mem_valid.
  - `badvaddr` = mem_addr; no bus request and no stall.
- Undefined:
  - addr_exc = 0; `exc_adel`, `exc_ades` and `badvaddr` tied 0.
  - Halfword/word addresses are forced aligned (addr[0], or addr[1:0], cleared) before issue.

Decomposition:
- Shared package / defines header:
  - l_s_type codes (LB_TYPE…SW_TYPE).
  - size encodings SIZE_B, SIZE_H, SIZE_W.
  - FSM state encodings.
- Sub-module `lsu_load_ext`: combinational rdata, addr[1:0], type → extended 32-bit result. Reused by the verification reference model.

Test Plan:
- LB at 0x1000_0003, bus returns 0x80FF_1234 one cycle after addr_ok:
  - expect data_size=0, wstrb=0.
  - expect mem_rdata=0xFFFF_FF80 and mem_done on the 4th cycle after start.
- SH at 0x1000_0002, rt=0x0000_ABCD, addr_ok and data_ok in the same cycle:
  - expect wstrb=4'b1100, wdata=0xABCD_ABCD.
  - expect REQ→DONE directly, stall for 2 cycles.
- LHU at 0x20, bus holds addr_ok low for 5 cycles:
  - expect data_req and all bus fields stable throughout.
  - expect mem_stall high until DONE; result 0x0000_xxxx zero-extended.
- LW issued, flush in WAIT, data_ok 2 cycles later:
  - expect no mem_done and mem_rdata unchanged.
  - expect stall released after data_ok, FSM back in IDLE.
- ADDR_EXC_EN defined, LW at 0x102:
  - expect exc_adel=1, badvaddr=0x102, data_req never asserted, mem_stall=0.
  - SW at 0x101 → exc_ades=1.
- resetn dropped while in REQ:
  - expect data_req=0 immediately (async) and FSM in IDLE.
  - after release, the next LW completes normally.
